// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter: one-cycle tx_en launch pulse,
// then waits for tx_done to rise and fall before launching the next word.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  flush,
  output logic                  tx_en,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_done,
  output logic [ADDR_W:0]       count,
  output logic                  empty,
  output logic                  full,
  output logic                  busy,
  output logic                  overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SET = 2'd1,
    S_WAIT_CLR = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic                  wr_fire;
  logic                  launch;
  logic                  tx_en_nxt;
  logic [DATA_WIDTH-1:0] tx_data_nxt;

  // Status flags come from the registered count only, so pointer wrap never matters.
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign wr_ready = !full;
  assign busy     = (state != S_IDLE);
  assign wr_fire  = wr_valid && !full && !flush;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (launch)   state_nxt = S_WAIT_SET;
      S_WAIT_SET: if (tx_done)  state_nxt = S_WAIT_CLR;
      S_WAIT_CLR: if (!tx_done) state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  // Output logic: launch pops the head word; a flush cycle never launches.
  always_comb begin
    launch      = 1'b0;
    tx_en_nxt   = 1'b0;
    tx_data_nxt = tx_data;
    if (state == S_IDLE && !empty && !flush) begin
      launch      = 1'b1;
      tx_en_nxt   = 1'b1;
      tx_data_nxt = mem[rd_ptr];
    end
  end

  // Storage array, not reset
  always_ff @(posedge clk) begin
    if (resetn && wr_fire) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy, sticky overflow and registered transmitter outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_en    <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_en   <= tx_en_nxt;
      tx_data <= tx_data_nxt;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr_fire)          wr_ptr   <= wr_ptr + ADDR_W'(1);
        if (launch)           rd_ptr   <= rd_ptr + ADDR_W'(1);
        if (wr_valid && full) overflow <= 1'b1;
        count <= count + CNT_W'(wr_fire) - CNT_W'(launch);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus pushes accepted words into a
// reference queue, a monitor pops and compares on every tx_en launch.
module tb_uart_tx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          resetn;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          flush;
  logic          tx_en;
  logic [DW-1:0] tx_data;
  logic          tx_done;
  logic [4:0]    count;
  logic          empty;
  logic          full;
  logic          busy;
  logic          overflow;

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .flush    (flush),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: words accepted but not yet launched, plus the sticky overflow flag
  logic [DW-1:0] exp_q[$];
  logic          exp_ovf;
  int            errors;
  int            checks;
  int            launches;
  int            tx_hold;
  int            done_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle; called and returns 2ns after a rising edge
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic f);
    wr_valid = v;
    wr_data  = d;
    flush    = f;
    if (f) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else if (v) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else                      exp_ovf = 1'b1;
    end
    @(posedge clk); #2;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    wr_valid = 1'b0;
    flush    = 1'b0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("FAIL %s timeout: queued=%0d busy=%0b expected 0 and 0", name, exp_q.size(), busy);
    end
  endtask

  // Transmitter model: tx_done rises 3 cycles after launch (stalled while tx_hold), stays high done_len cycles
  int tdelay;
  int tlen;
  initial begin
    tx_done = 1'b0;
    tdelay  = 0;
    tlen    = 0;
    forever begin
      @(posedge clk); #3;
      if (!resetn) begin
        tx_done = 1'b0;
        tdelay  = 0;
        tlen    = 0;
      end else if (tx_en) begin
        tdelay = 3;
      end else if (tdelay > 0) begin
        if (tx_hold == 0) begin
          tdelay--;
          if (tdelay == 0) begin
            tx_done = 1'b1;
            tlen    = done_len;
          end
        end
      end else if (tlen > 0) begin
        tlen--;
        if (tlen == 0) tx_done = 1'b0;
      end
    end
  end

  // Monitor: samples 1ns after each rising edge
  logic          prev_tx_en;
  logic [DW-1:0] last_data;
  logic [DW-1:0] mon_e;
  initial begin
    prev_tx_en = 1'b0;
    last_data  = '0;
    launches   = 0;
    forever begin
      @(posedge clk); #1;
      if (!resetn) begin
        chk("rst_count", count, 0);
        chk("rst_tx_en", tx_en, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_empty", empty, 1);
        prev_tx_en = 1'b0;
        last_data  = '0;
      end else begin
        if (tx_en) begin
          chk("tx_en_single_cycle", prev_tx_en, 0);
          chk("tx_en_while_done", tx_done, 0);
          chk("busy_on_launch", busy, 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_launch: got tx_data=%0h expected no launch at %0t", tx_data, $time);
          end else begin
            mon_e = exp_q.pop_front();
            chk("tx_data_order", tx_data, mon_e);
          end
          launches++;
          last_data = tx_data;
        end else begin
          chk("tx_data_stable", tx_data, last_data);
        end
        chk("count", count, exp_q.size());
        chk("empty", empty, exp_q.size() == 0);
        chk("full", full, exp_q.size() == DEPTH);
        chk("wr_ready", wr_ready, exp_q.size() != DEPTH);
        chk("overflow", overflow, exp_ovf);
        prev_tx_en = tx_en;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  int sent;
  int iter;
  int l0;
  int seen;
  int n;

  initial begin
    errors   = 0;
    checks   = 0;
    exp_ovf  = 1'b0;
    tx_hold  = 0;
    done_len = 16;

    // Reset held 3 cycles with wr_valid asserted
    resetn   = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h5A;
    flush    = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    resetn   = 1'b1;
    drive(0, 8'h00, 0);

    // Single byte: launch exactly one cycle after the write edge
    drive(1, 8'hA5, 0);
    wr_valid = 1'b0;
    @(posedge clk); #1;
    chk("single_tx_en", tx_en, 1);
    chk("single_tx_data", tx_data, 8'hA5);
    @(posedge clk); #1;
    chk("single_tx_en_end", tx_en, 0);
    chk("single_busy", busy, 1);
    seen = 0;
    n    = 0;
    while (!(seen == 1 && !tx_done) && n < 100) begin
      @(posedge clk); #1;
      if (tx_done) begin
        seen = 1;
        chk("single_busy_during_done", busy, 1);
      end
      n++;
    end
    chk("single_done_seen", seen, 1);
    chk("single_busy_after_done", busy, 0);
    chk("single_count", count, 0);
    #1;

    // Fill with transmitter stalled: first word launches, 16 stored, extra word dropped
    done_len = 3;
    tx_hold  = 1;
    for (int i = 0; i < 18; i++) drive(1, DW'(i), 0);
    drive(0, 8'h00, 0);
    chk("fill_full", full, 1);
    chk("fill_wr_ready", wr_ready, 0);
    chk("fill_count", count, DEPTH);
    chk("fill_overflow", overflow, 1);
    tx_hold = 0;
    wait_idle(3000, "fill_drain");

    // Wrap: 40 random words at random gaps
    sent = 0;
    iter = 0;
    while (sent < 40 && iter < 4000) begin
      done_len = $urandom_range(1, 4);
      if ($urandom_range(0, 2) == 0 || exp_q.size() >= DEPTH) begin
        drive(0, 8'h00, 0);
      end else begin
        drive(1, DW'($urandom), 0);
        sent++;
      end
      iter++;
    end
    chk("wrap_sent", sent, 40);
    wait_idle(3000, "wrap_drain");

    // Flush with 5 queued and 1 in flight; overflow is still set from the fill
    done_len = 3;
    tx_hold  = 1;
    for (int i = 0; i < 6; i++) drive(1, DW'(8'h40 + i), 0);
    repeat (3) drive(0, 8'h00, 0);
    chk("flush_pre_count", count, 5);
    chk("flush_pre_busy", busy, 1);
    drive(1, 8'h77, 1);
    drive(0, 8'h00, 0);
    chk("flush_count", count, 0);
    chk("flush_overflow", overflow, 0);
    l0      = launches;
    tx_hold = 0;
    wait_idle(200, "flush_inflight");
    repeat (30) drive(0, 8'h00, 0);
    chk("flush_no_launch", launches, l0);

    // Reset while waiting for tx_done with 3 queued
    tx_hold = 1;
    for (int i = 0; i < 4; i++) drive(1, DW'(8'hC0 + i), 0);
    repeat (2) drive(0, 8'h00, 0);
    chk("rstmid_busy_pre", busy, 1);
    chk("rstmid_count_pre", count, 3);
    resetn   = 1'b0;
    wr_valid = 1'b0;
    exp_q.delete();
    exp_ovf  = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    resetn  = 1'b1;
    tx_hold = 0;
    l0      = launches;
    repeat (20) drive(0, 8'h00, 0);
    chk("rstmid_no_launch", launches, l0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_count", count, 0);
    drive(1, 8'h3C, 0);
    wait_idle(200, "rstmid_new_write");
    chk("rstmid_relaunch", launches, l0 + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
